// File: rtl/pc_predict_unit_if.sv
// Fetch PC-select bundle: pipeline stage inputs in, selected fetch PC and RAS status out.
// The master drives pipeline state; the slave (predict unit) returns the fetch PC.
interface pc_predict_unit_if #(
    parameter int PC_W      = 64,
    parameter int RAS_DEPTH = 8
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic            F_stall;
    logic            f_valid;
    logic [3:0]      f_icode;
    logic [PC_W-1:0] f_valC;
    logic [PC_W-1:0] f_valP;
    logic [3:0]      M_icode;
    logic            M_cnd;
    logic [PC_W-1:0] M_valA;
    logic [3:0]      W_icode;
    logic [PC_W-1:0] W_valM;
    logic [PC_W-1:0] W_valP;
    logic [PC_W-1:0] W_predPC;
    logic [PC_W-1:0] f_pc;
    logic [PC_W-1:0] F_predPC;
    logic            redirect;
    logic [CW-1:0]   ras_count;

    modport master (
        output F_stall, f_valid, f_icode, f_valC, f_valP,
               M_icode, M_cnd, M_valA, W_icode, W_valM, W_valP, W_predPC,
        input  f_pc, F_predPC, redirect, ras_count
    );

    modport slave (
        input  F_stall, f_valid, f_icode, f_valC, f_valP,
               M_icode, M_cnd, M_valA, W_icode, W_valM, W_valP, W_predPC,
        output f_pc, F_predPC, redirect, ras_count
    );
endinterface

// File: rtl/pc_predict_unit.sv
// Fetch PC select with F_predPC register and return-address stack prediction.
// A speculative RAS is used in fetch; a committed RAS updated from W repairs it on any redirect.
module pc_predict_unit #(
    parameter int              PC_W      = 64,
    parameter int              RAS_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             rst,
    pc_predict_unit_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    localparam logic [3:0] I_JXX  = 4'd7;
    localparam logic [3:0] I_CALL = 4'd8;
    localparam logic [3:0] I_RET  = 4'd9;

    logic [PC_W-1:0] sp_stk_q [RAS_DEPTH];
    logic [PC_W-1:0] sp_stk_d [RAS_DEPTH];
    logic [PW-1:0]   sp_top_q, sp_top_d;
    logic [CW-1:0]   sp_cnt_q, sp_cnt_d;

    logic [PC_W-1:0] cm_stk_q [RAS_DEPTH];
    logic [PC_W-1:0] cm_stk_d [RAS_DEPTH];
    logic [PW-1:0]   cm_top_q, cm_top_d;
    logic [CW-1:0]   cm_cnt_q, cm_cnt_d;

    logic [PC_W-1:0] pred_q, pred_d;

    logic ret_mis, jmp_mis, redirect, fetch_en;
    logic [PC_W-1:0] f_pc;

    assign ret_mis  = (bus.W_icode == I_RET) && (bus.W_valM != bus.W_predPC);
    assign jmp_mis  = (bus.M_icode == I_JXX) && !bus.M_cnd;
    assign redirect = ret_mis | jmp_mis;
    assign fetch_en = bus.f_valid && !bus.F_stall;

    // W is older than M, so a ret recovery overrides a jXX recovery.
    assign f_pc = ret_mis ? bus.W_valM :
                  jmp_mis ? bus.M_valA : pred_q;

    assign bus.f_pc      = f_pc;
    assign bus.F_predPC  = pred_q;
    assign bus.redirect  = redirect;
    assign bus.ras_count = sp_cnt_q;

    always_comb begin
        cm_stk_d = cm_stk_q;
        cm_top_d = cm_top_q;
        cm_cnt_d = cm_cnt_q;
        if (bus.W_icode == I_CALL) begin
            cm_top_d           = cm_top_q + PW'(1);
            cm_stk_d[cm_top_d] = bus.W_valP;
            if (cm_cnt_q != FULL) cm_cnt_d = cm_cnt_q + CW'(1);
        end else if (bus.W_icode == I_RET && cm_cnt_q != '0) begin
            cm_top_d = cm_top_q - PW'(1);
            cm_cnt_d = cm_cnt_q - CW'(1);
        end
    end

    // Repair base is the committed stack after this cycle's W update; fetch op is layered on top.
    always_comb begin
        if (redirect) begin
            sp_stk_d = cm_stk_d;
            sp_top_d = cm_top_d;
            sp_cnt_d = cm_cnt_d;
        end else begin
            sp_stk_d = sp_stk_q;
            sp_top_d = sp_top_q;
            sp_cnt_d = sp_cnt_q;
        end
        pred_d = pred_q;
        if (fetch_en) begin
            case (bus.f_icode)
                I_JXX: pred_d = bus.f_valC;
                I_CALL: begin
                    pred_d             = bus.f_valC;
                    sp_top_d           = sp_top_d + PW'(1);
                    sp_stk_d[sp_top_d] = bus.f_valP;
                    if (sp_cnt_d != FULL) sp_cnt_d = sp_cnt_d + CW'(1);
                end
                I_RET: begin
                    if (sp_cnt_d != '0) begin
                        pred_d   = sp_stk_d[sp_top_d];
                        sp_top_d = sp_top_d - PW'(1);
                        sp_cnt_d = sp_cnt_d - CW'(1);
                    end else begin
                        pred_d = bus.f_valP;
                    end
                end
                default: pred_d = bus.f_valP;
            endcase
        end else if (!bus.F_stall) begin
            pred_d = f_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_q   <= RESET_PC;
            sp_top_q <= '0;
            sp_cnt_q <= '0;
            cm_top_q <= '0;
            cm_cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                sp_stk_q[i] <= '0;
                cm_stk_q[i] <= '0;
            end
        end else begin
            pred_q   <= pred_d;
            sp_top_q <= sp_top_d;
            sp_cnt_q <= sp_cnt_d;
            cm_top_q <= cm_top_d;
            cm_cnt_q <= cm_cnt_d;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                sp_stk_q[i] <= sp_stk_d[i];
                cm_stk_q[i] <= cm_stk_d[i];
            end
        end
    end
endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
- Parametrised successor to the pipeline's fetch PC-select logic.
- Selects the fetch PC from three sources: predicted PC, jXX mispredict recovery (M stage) and ret recovery (W stage).
- Owns the F_predPC pipeline register and adds a return-address stack (RAS), so ret is predicted in fetch instead of stalling.
- Keeps a speculative RAS and a committed RAS; on any redirect the speculative RAS is repaired from the committed copy.

Parameters:
PC_W, 64, width of all PC/address values
RAS_DEPTH, 8, return-address stack entries (power of 2, >=2)
RESET_PC, 0, F_predPC value after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
F_stall  in  1  hold F_predPC and speculative RAS this cycle
f_valid  in  1  fetched instruction at f_pc is valid
f_icode  in  4  icode of instruction fetched at f_pc
f_valC  in  PC_W  call/jump target of fetched instruction
f_valP  in  PC_W  fall-through PC of fetched instruction
M_icode  in  4  icode in M stage
M_cnd  in  1  condition result in M stage
M_valA  in  PC_W  fall-through PC carried by jXX
W_icode  in  4  icode in W stage
W_valM  in  PC_W  actual return address popped by ret
W_valP  in  PC_W  return address pushed by call in W
W_predPC  in  PC_W  target predicted in fetch for the W instruction
f_pc  out  PC_W  selected fetch PC (combinational)
F_predPC  out  PC_W  registered predicted next PC
redirect  out  1  combinational, 1 when f_pc is a recovery target (pipeline flush request)
ras_count  out  $clog2(RAS_DEPTH)+1  speculative RAS occupancy

Behaviour:
- Reset (async): F_predPC=RESET_PC, both RAS empty, ras_count=0.
- Redirect conditions:
  - ret_mis = (W_icode==9) && (W_valM != W_predPC)
  - jmp_mis = (M_icode==7) && !M_cnd
- f_pc priority:
  - ret_mis -> W_valM (W is the older instruction, so it wins over M).
  - else jmp_mis -> M_valA.
  - else F_predPC.
- redirect = ret_mis | jmp_mis.
- A correctly predicted ret (W_valM==W_predPC) produces no redirect.
- Prediction (fetch_en = f_valid && !F_stall; next F_predPC chosen by f_icode):
  - 7 (jXX, always-taken): f_valC.
  - 8 (call): f_valC; push f_valP on the speculative RAS.
  - 9 (ret), RAS non-empty: top of the speculative RAS; pop.
  - 9 (ret), RAS empty: f_valP. This is a deliberate mispredict, corrected at W.
  - other: f_valP.
  - F_stall=1: F_predPC and speculative RAS hold. redirect and f_pc are still driven.
  - f_valid=0 and !F_stall: F_predPC <= f_pc; no RAS operation.
- Committed RAS, updated every cycle regardless of F_stall:
  - W_icode==8: push W_valP.
  - W_icode==9: pop; a pop on empty leaves it empty.
- Repair:
  - When redirect=1, the speculative RAS is loaded with the committed RAS value after this cycle's W update.
  - The fetch-side push/pop is then applied on top, if fetch_en.
  - Net effect: single-cycle latency; the state is correct at the next edge.
- Overflow: push when full overwrites the oldest entry (circular pointer); count saturates at RAS_DEPTH. Same rule for both stacks.
- Underflow: pop when empty is a no-op; count stays 0.
- Storage: each stack is a circular array of RAS_DEPTH x PC_W with a top pointer and a count. Repair copies array, pointer and count.
- All PC arithmetic is done by the caller; the block compares and muxes only and performs no addition.
- Reset asserted mid-operation clears both stacks immediately. f_pc then equals RESET_PC unless a redirect input is active.

Test Plan:
- Reset, then all inputs idle (icode 0, f_valP=0x0A) -> f_pc=0x0, F_predPC=0x0A after one edge, redirect=0, ras_count=0.
- Fetch call (f_valC=0x100, f_valP=0x20), then ret -> F_predPC=0x100, then 0x20; ras_count 1 then 0. Later W ret with W_valM=0x20, W_predPC=0x20 -> redirect=0.
- M_icode=7, M_cnd=0, M_valA=0x44, and simultaneously W ret with W_valM=0x80, W_predPC=0x90 -> f_pc=0x80, redirect=1 (W priority).
- RAS_DEPTH=8: 9 calls with f_valP=0x10..0x90, then 8 rets -> ras_count caps at 8. Pops return 0x90 down to 0x20; ras_count=0 after the eighth ret.
- Speculative push of 0x55 with the committed RAS empty, then jmp_mis -> speculative RAS restored to empty (ras_count=0) at the next edge.
- F_stall=1 while fetching a call -> F_predPC and ras_count unchanged. Assert rst mid-stack -> ras_count=0 and F_predPC=RESET_PC without waiting for a clock edge.
